// File: rtl/eth_pkg.sv
// Shared types and constants for the SPI Ethernet receive controller.
package eth_pkg;

  localparam int ADDR_W        = 11;
  localparam int BUF_BYTES_DEF = 1536;

  typedef enum logic [2:0] {
    CLEAR,
    WAIT_IDLE,
    ARMED,
    RECEIVING,
    SETTLE,
    READY
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/eth_rx_ctrl.sv
// Receive sequencer: arms the SPI receiver for one frame, latches its length,
// lends the buffer RAM to the CPU for readout and re-arms on acknowledge.
module eth_rx_ctrl
  import eth_pkg::*;
#(
  parameter int BUF_BYTES     = BUF_BYTES_DEF,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic [ADDR_W-1:0] recv_byte_cnt,
  output logic              rx_n_rst,
  output logic              rx_ena,
  output logic              buf_sel,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              buf_n_oe,
  input  logic [7:0]        buf_d,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_rd_data,
  output logic              cpu_rd_valid,
  output logic              cpu_rd_err,
  output logic              frame_ready,
  output logic [ADDR_W-1:0] frame_len,
  output logic              frame_ovf,
  input  logic              frame_ack,
  output logic [7:0]        drop_cnt
);

  localparam logic [31:0]       BUF_LIMIT   = BUF_BYTES;
  localparam logic [ADDR_W-1:0] RST_LAST    = ADDR_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] SETTLE_LAST = ADDR_W'(SETTLE_CYCLES - 1);

  rx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              cs_s, cs_prev_q;
  logic              cs_fall, cs_rise;
  logic              dropped_q;
  logic [7:0]        drop_cnt_q;
  logic              frame_ready_q, frame_ovf_q;
  logic [ADDR_W-1:0] frame_len_q;
  logic              rd_pend_q, ack_pend_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic              buf_n_oe_q;
  logic [7:0]        cpu_rd_data_q;
  logic              cpu_rd_valid_q, cpu_rd_err_q;
  logic              drop_evt, drop_inc, frame_set, ack_go, rd_accept, recv_ovf;

  sync_2ff #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (spi_cs_n),
    .q_o   (cs_s)
  );

  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign recv_ovf = {{(32-ADDR_W){1'b0}}, recv_byte_cnt} > BUF_LIMIT;

  // An ack that lands while a read is still in flight waits for that read to finish.
  assign ack_go    = (state_q == READY) && (frame_ack || ack_pend_q) && !rd_pend_q;
  assign rd_accept = (state_q == READY) && cpu_rd && !rd_pend_q && !ack_go;

  // One CS-low period is counted at most once, even if it is seen both as a
  // fall during CLEAR and as CS still low when CLEAR finishes.
  assign drop_inc = drop_evt && !dropped_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_n_rst  = 1'b1;
    rx_ena    = 1'b0;
    buf_sel   = 1'b0;
    drop_evt  = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      CLEAR: begin
        rx_n_rst = 1'b0;
        drop_evt = cs_fall;
        if (cnt_q == RST_LAST) begin
          cnt_d = '0;
          if (!cs_s) begin
            state_d  = WAIT_IDLE;
            drop_evt = 1'b1;
          end else begin
            state_d = ARMED;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (cs_s) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      ARMED: begin
        rx_ena = 1'b1;
        if (cs_fall) state_d = RECEIVING;
      end
      RECEIVING: begin
        rx_ena = 1'b1;
        if (cs_rise) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LAST;
        end
      end
      SETTLE: begin
        drop_evt = cs_fall;
        if (cnt_q == '0) begin
          state_d   = READY;
          frame_set = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      READY: begin
        buf_sel  = 1'b1;
        drop_evt = cs_fall;
        if (ack_go) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= CLEAR;
      cnt_q          <= '0;
      cs_prev_q      <= 1'b1;
      dropped_q      <= 1'b0;
      drop_cnt_q     <= '0;
      frame_ready_q  <= 1'b0;
      frame_len_q    <= '0;
      frame_ovf_q    <= 1'b0;
      rd_pend_q      <= 1'b0;
      ack_pend_q     <= 1'b0;
      buf_addr_q     <= '0;
      buf_n_oe_q     <= 1'b1;
      cpu_rd_data_q  <= '0;
      cpu_rd_valid_q <= 1'b0;
      cpu_rd_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cs_prev_q <= cs_s;

      if (cs_rise)       dropped_q <= 1'b0;
      else if (drop_inc) dropped_q <= 1'b1;
      if (drop_inc && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;

      if (frame_set) begin
        frame_ready_q <= 1'b1;
        frame_len_q   <= recv_ovf ? BUF_LIMIT[ADDR_W-1:0] : recv_byte_cnt;
        frame_ovf_q   <= recv_ovf;
      end else if (ack_go) begin
        frame_ready_q <= 1'b0;
      end

      if (ack_go)                                             ack_pend_q <= 1'b0;
      else if (state_q == READY && frame_ack && rd_pend_q)    ack_pend_q <= 1'b1;

      // Address/OE phase in the cycle after the request, data capture one cycle later.
      rd_pend_q  <= rd_accept;
      buf_n_oe_q <= ~rd_accept;
      if (rd_accept) buf_addr_q <= cpu_addr;
      cpu_rd_valid_q <= rd_pend_q;
      if (rd_pend_q) cpu_rd_data_q <= buf_d;
      cpu_rd_err_q <= cpu_rd & ~rd_accept;
    end
  end

  assign drop_cnt     = drop_cnt_q;
  assign frame_ready  = frame_ready_q;
  assign frame_len    = frame_len_q;
  assign frame_ovf    = frame_ovf_q;
  assign buf_addr     = buf_addr_q;
  assign buf_n_oe     = buf_n_oe_q;
  assign cpu_rd_data  = cpu_rd_data_q;
  assign cpu_rd_valid = cpu_rd_valid_q;
  assign cpu_rd_err   = cpu_rd_err_q;

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// Directed, table-driven bench for eth_rx_ctrl with a behavioural buffer RAM.
module tb_eth_rx_ctrl;

  typedef struct {
    logic [10:0] cnt;
    logic [10:0] len;
    logic        ovf;
  } frame_vec_t;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
  } rd_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_cs_n;
  logic [10:0] recv_byte_cnt;
  logic        rx_n_rst, rx_ena, buf_sel, buf_n_oe;
  logic [10:0] buf_addr;
  logic [7:0]  buf_d;
  logic        cpu_rd;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_rd_data;
  logic        cpu_rd_valid, cpu_rd_err;
  logic        frame_ready, frame_ovf, frame_ack;
  logic [10:0] frame_len;
  logic [7:0]  drop_cnt;

  logic [7:0]  ram [2048];
  int          checks = 0;
  int          failures = 0;
  int          expDrops = 0;
  frame_vec_t  fvec [6];
  rd_vec_t     rvec [5];

  always #5 clk = ~clk;

  // RAM drives a marker value when not enabled so a mistimed capture shows up.
  assign buf_d = buf_n_oe ? 8'hEE : ram[buf_addr];

  eth_rx_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .spi_cs_n      (spi_cs_n),
    .recv_byte_cnt (recv_byte_cnt),
    .rx_n_rst      (rx_n_rst),
    .rx_ena        (rx_ena),
    .buf_sel       (buf_sel),
    .buf_addr      (buf_addr),
    .buf_n_oe      (buf_n_oe),
    .buf_d         (buf_d),
    .cpu_rd        (cpu_rd),
    .cpu_addr      (cpu_addr),
    .cpu_rd_data   (cpu_rd_data),
    .cpu_rd_valid  (cpu_rd_valid),
    .cpu_rd_err    (cpu_rd_err),
    .frame_ready   (frame_ready),
    .frame_len     (frame_len),
    .frame_ovf     (frame_ovf),
    .frame_ack     (frame_ack),
    .drop_cnt      (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic [10:0] addr, input logic ack);
    cpu_rd    = rd;
    cpu_addr  = addr;
    frame_ack = ack;
    tick();
  endtask

  // Entered on the first observed CLEAR cycle; expects three more, then ARMED.
  task automatic waitArmedExact();
    checkOutput("clear_n_rst", 32'(rx_n_rst), 32'd0);
    checkOutput("clear_ena", 32'(rx_ena), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("clear_hold", 32'(rx_n_rst), 32'd0);
    end
    tick();
    checkOutput("armed_n_rst", 32'(rx_n_rst), 32'd1);
    checkOutput("armed_ena", 32'(rx_ena), 32'd1);
  endtask

  task automatic sendFrame(input logic [10:0] cnt, input logic [10:0] len, input logic ovf);
    spi_cs_n = 1'b0;
    tickN(6);
    checkOutput("recv_ena", 32'(rx_ena), 32'd1);
    recv_byte_cnt = cnt;
    spi_cs_n = 1'b1;
    tickN(3);
    checkOutput("settle_ena", 32'(rx_ena), 32'd0);
    tickN(2);
    checkOutput("ready_early", 32'(frame_ready), 32'd0);
    tick();
    checkOutput("ready", 32'(frame_ready), 32'd1);
    checkOutput("ready_buf_sel", 32'(buf_sel), 32'd1);
    checkOutput("frame_len", 32'(frame_len), 32'(len));
    checkOutput("frame_ovf", 32'(frame_ovf), 32'(ovf));
  endtask

  task automatic ackFrame();
    applyStimulus(1'b0, 11'd0, 1'b1);
    frame_ack = 1'b0;
    checkOutput("ack_ready", 32'(frame_ready), 32'd0);
    checkOutput("ack_buf_sel", 32'(buf_sel), 32'd0);
    waitArmedExact();
  endtask

  task automatic dropPulse();
    spi_cs_n = 1'b0;
    tickN(3);
    spi_cs_n = 1'b1;
    tickN(3);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; spi_cs_n = 1'b1; recv_byte_cnt = '0;
    cpu_rd = 1'b0; cpu_addr = '0; frame_ack = 1'b0;
    for (int i = 0; i < 2048; i++) ram[i] = 8'(i) ^ 8'h3C;
    ram[5] = 8'hA5;

    fvec[0] = '{11'd0,    11'd0,    1'b0};
    fvec[1] = '{11'd1,    11'd1,    1'b0};
    fvec[2] = '{11'd1536, 11'd1536, 1'b0};
    fvec[3] = '{11'd1537, 11'd1536, 1'b1};
    fvec[4] = '{11'd1600, 11'd1536, 1'b1};
    fvec[5] = '{11'd2047, 11'd1536, 1'b1};

    rvec[0] = '{11'd5,    8'hA5};
    rvec[1] = '{11'd0,    8'h3C};
    rvec[2] = '{11'd2047, 8'hC3};
    rvec[3] = '{11'd100,  8'h58};
    rvec[4] = '{11'd300,  8'h10};

    tickN(3);
    rst = 1'b0;
    checkOutput("rst_buf_sel", 32'(buf_sel), 32'd0);
    checkOutput("rst_n_oe", 32'(buf_n_oe), 32'd1);
    checkOutput("rst_ready", 32'(frame_ready), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
    checkOutput("rst_valid", 32'(cpu_rd_valid), 32'd0);
    waitArmedExact();

    applyStimulus(1'b1, 11'd3, 1'b0);
    checkOutput("armed_rd_err", 32'(cpu_rd_err), 32'd1);
    checkOutput("armed_rd_n_oe", 32'(buf_n_oe), 32'd1);
    applyStimulus(1'b0, 11'd0, 1'b1);
    frame_ack = 1'b0;
    checkOutput("armed_ack_ign", 32'(rx_ena), 32'd1);
    checkOutput("armed_err_clr", 32'(cpu_rd_err), 32'd0);

    sendFrame(11'd64, 11'd64, 1'b0);

    foreach (rvec[k]) begin
      applyStimulus(1'b1, rvec[k].addr, 1'b0);
      checkOutput("rd_n_oe", 32'(buf_n_oe), 32'd0);
      checkOutput("rd_addr", 32'(buf_addr), 32'(rvec[k].addr));
      applyStimulus(1'b0, 11'd0, 1'b0);
      checkOutput("rd_valid", 32'(cpu_rd_valid), 32'd1);
      checkOutput("rd_data", 32'(cpu_rd_data), 32'(rvec[k].data));
      checkOutput("rd_n_oe_off", 32'(buf_n_oe), 32'd1);
      checkOutput("rd_err", 32'(cpu_rd_err), 32'd0);
    end

    applyStimulus(1'b1, 11'd7, 1'b0);
    checkOutput("b2b_first_err", 32'(cpu_rd_err), 32'd0);
    applyStimulus(1'b1, 11'd7, 1'b0);
    checkOutput("b2b_err", 32'(cpu_rd_err), 32'd1);
    checkOutput("b2b_valid", 32'(cpu_rd_valid), 32'd1);
    checkOutput("b2b_data", 32'(cpu_rd_data), 32'h3B);
    applyStimulus(1'b0, 11'd0, 1'b0);
    checkOutput("b2b_valid_end", 32'(cpu_rd_valid), 32'd0);

    spi_cs_n = 1'b0;
    tickN(6);
    spi_cs_n = 1'b1;
    tickN(4);
    expDrops = 1;
    checkOutput("ready_drop", 32'(drop_cnt), 32'(expDrops));
    checkOutput("ready_drop_len", 32'(frame_len), 32'd64);
    checkOutput("ready_drop_rdy", 32'(frame_ready), 32'd1);

    applyStimulus(1'b1, 11'd9, 1'b0);
    applyStimulus(1'b0, 11'd0, 1'b1);
    frame_ack = 1'b0;
    checkOutput("defer_valid", 32'(cpu_rd_valid), 32'd1);
    checkOutput("defer_data", 32'(cpu_rd_data), 32'h35);
    checkOutput("defer_ready", 32'(frame_ready), 32'd1);
    tick();
    checkOutput("defer_done", 32'(frame_ready), 32'd0);
    waitArmedExact();

    foreach (fvec[k]) begin
      sendFrame(fvec[k].cnt, fvec[k].len, fvec[k].ovf);
      ackFrame();
    end

    // CS goes low during CLEAR and is still low when the clear period ends.
    sendFrame(11'd20, 11'd20, 1'b0);
    applyStimulus(1'b0, 11'd0, 1'b1);
    frame_ack = 1'b0;
    spi_cs_n = 1'b0;
    tickN(5);
    expDrops = 2;
    checkOutput("wait_n_rst", 32'(rx_n_rst), 32'd1);
    checkOutput("wait_ena", 32'(rx_ena), 32'd0);
    checkOutput("wait_drop", 32'(drop_cnt), 32'(expDrops));
    spi_cs_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (!rx_n_rst) seen = 1'b1;
    end
    checkOutput("wait_to_clear", 32'(seen), 32'd1);
    waitArmedExact();
    checkOutput("wait_drop_hold", 32'(drop_cnt), 32'(expDrops));

    sendFrame(11'd100, 11'd100, 1'b0);
    for (int i = 0; i < 300; i++) begin
      dropPulse();
      if (i == 9) checkOutput("drop_partial", 32'(drop_cnt), 32'(expDrops + 10));
    end
    tickN(3);
    checkOutput("drop_sat", 32'(drop_cnt), 32'd255);
    checkOutput("drop_sat_len", 32'(frame_len), 32'd100);
    checkOutput("drop_sat_rdy", 32'(frame_ready), 32'd1);
    ackFrame();

    spi_cs_n = 1'b0;
    tickN(5);
    checkOutput("mid_recv_ena", 32'(rx_ena), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_ena", 32'(rx_ena), 32'd0);
    checkOutput("mid_rst_n_rst", 32'(rx_n_rst), 32'd0);
    checkOutput("mid_rst_drop", 32'(drop_cnt), 32'd0);
    checkOutput("mid_rst_len", 32'(frame_len), 32'd0);
    checkOutput("mid_rst_buf_sel", 32'(buf_sel), 32'd0);
    spi_cs_n = 1'b1;
    tickN(2);
    rst = 1'b0;
    waitArmedExact();

    sendFrame(11'd10, 11'd10, 1'b0);
    applyStimulus(1'b1, 11'd5, 1'b0);
    cpu_rd = 1'b0;
    checkOutput("rdrst_n_oe", 32'(buf_n_oe), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("rdrst_valid", 32'(cpu_rd_valid), 32'd0);
    checkOutput("rdrst_n_oe_off", 32'(buf_n_oe), 32'd1);
    checkOutput("rdrst_ready", 32'(frame_ready), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("rdrst_valid2", 32'(cpu_rd_valid), 32'd0);
    checkOutput("rdrst_data", 32'(cpu_rd_data), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
